// File: rtl/opcode_sequencer_if.sv
// opcode_sequencer_if
//   Groups the signals exchanged between the 6502 opcode sequencer and the
//   datapath board. clk and clr_n are kept as plain ports on the sequencer.
//   Board -> sequencer:
//     din       8   data pins, opcode/operand byte
//     carry_in  1   status register carry bit
//     rdy       1   stall request, active low
//   Sequencer -> board:
//     ctrl     24   datapath control strobes
//     rw        1   1 = read, 0 = write
//     sync      1   opcode fetch cycle marker
//     t_state   4   current state code
//     ir        8   instruction register
//     illegal   1   sticky unsupported-opcode flag
interface opcode_sequencer_if;
  logic [7:0]  din;
  logic        carry_in;
  logic        rdy;
  logic [23:0] ctrl;
  logic        rw;
  logic        sync;
  logic [3:0]  t_state;
  logic [7:0]  ir;
  logic        illegal;

  // Sequencer side.
  modport master (
    input  din, carry_in, rdy,
    output ctrl, rw, sync, t_state, ir, illegal
  );

  // Board side.
  modport slave (
    output din, carry_in, rdy,
    input  ctrl, rw, sync, t_state, ir, illegal
  );
endinterface

// File: rtl/opcode_sequencer.sv
// opcode_sequencer
//   Instruction timing and control generator for the 6502 datapath board.
//   Latches each opcode from the data pins at the end of FETCH and steps a
//   fixed per-instruction state machine, driving the 24 datapath strobes in
//   every cycle. Supported: LDA #imm, LDA abs, ADC #imm, ADC abs, STA abs, NOP.
//   Ports:
//     clk    in   system clock, rising edge
//     clr_n  in   asynchronous active-low reset
//     bus    opcode_sequencer_if.master (din, carry_in, rdy in;
//            ctrl, rw, sync, t_state, ir, illegal out)
module opcode_sequencer (
  input  logic                 clk,
  input  logic                 clr_n,
  opcode_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DEC   = 4'd1,
    S_ADL   = 4'd2,
    S_ADH   = 4'd3,
    S_MEM   = 4'd4,
    S_RDM   = 4'd5,
    S_STM   = 4'd6,
    S_LDALU = 4'd7,
    S_ALU   = 4'd8,
    S_WBL   = 4'd9,
    S_WBA   = 4'd10
  } state_t;

  // Strobe bit positions within ctrl.
  localparam int B_DLWA     = 0;
  localparam int B_DLDBOA   = 1;
  localparam int B_DLADLOA  = 2;
  localparam int B_DLADHOA  = 3;
  localparam int B_PCLINC   = 4;
  localparam int B_PCLADLOA = 5;
  localparam int B_PCHADHOA = 6;
  localparam int B_ABLWA    = 7;
  localparam int B_ABHWA    = 8;
  localparam int B_DBSB     = 9;
  localparam int B_ACCWA    = 10;
  localparam int B_ACCSBOA  = 11;
  localparam int B_ACCDBOA  = 12;
  localparam int B_PREDBWA  = 13;
  localparam int B_PREADLWA = 14;
  localparam int B_PRESBWA  = 15;
  localparam int B_ORS      = 16;
  localparam int B_SUMS     = 17;
  localparam int B_CIN      = 18;
  localparam int B_SALUWA   = 19;
  localparam int B_ALUADLOA = 20;
  localparam int B_ALUSBOA  = 21;
  localparam int B_DORWA    = 22;
  localparam int B_DOROA    = 23;

  // Program-counter read: PC onto the address bus, data latch loads, PC steps.
  localparam logic [23:0] PCRD =
    (24'd1 << B_PCLADLOA) | (24'd1 << B_PCHADHOA) | (24'd1 << B_ABLWA) |
    (24'd1 << B_ABHWA)    | (24'd1 << B_DLWA)     | (24'd1 << B_PCLINC);

  // Strobes that write or increment board state; these are killed during a
  // stall so the held state does not repeat its side effects.
  localparam logic [23:0] WR_MASK =
    (24'd1 << B_DLWA)    | (24'd1 << B_PCLINC)   | (24'd1 << B_ABLWA)   |
    (24'd1 << B_ABHWA)   | (24'd1 << B_ACCWA)    | (24'd1 << B_PREDBWA) |
    (24'd1 << B_PREADLWA)| (24'd1 << B_PRESBWA)  | (24'd1 << B_SALUWA)  |
    (24'd1 << B_DORWA);

  state_t      r_state;
  logic [7:0]  r_ir;
  logic        r_illegal;

  state_t      w_next;
  logic        w_ill_set;
  logic        w_dec_fetch;
  logic [23:0] w_ctrl_raw;
  logic        w_rw;
  logic        w_sync;

  // Opcodes that fetch an operand byte during DEC.
  always_comb begin
    w_dec_fetch = 1'b0;
    case (r_ir)
      8'hA9, 8'h69, 8'hAD, 8'h6D, 8'h8D: w_dec_fetch = 1'b1;
      default:                           w_dec_fetch = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = S_FETCH;
    w_ill_set = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_DEC;
      S_DEC: begin
        case (r_ir)
          8'hA9:               w_next = S_WBL;
          8'h69:               w_next = S_LDALU;
          8'hAD, 8'h6D, 8'h8D: w_next = S_ADL;
          8'hEA:               w_next = S_FETCH;
          default: begin
            w_next    = S_FETCH;
            w_ill_set = 1'b1;
          end
        endcase
      end
      S_ADL:   w_next = S_ADH;
      S_ADH:   w_next = S_MEM;
      S_MEM:   w_next = (r_ir == 8'h8D) ? S_STM : S_RDM;
      S_RDM: begin
        if (r_ir == 8'hAD)      w_next = S_WBL;
        else if (r_ir == 8'h6D) w_next = S_LDALU;
        else                    w_next = S_FETCH;
      end
      S_STM:   w_next = S_FETCH;
      S_LDALU: w_next = S_ALU;
      S_ALU:   w_next = S_WBA;
      S_WBL:   w_next = S_FETCH;
      S_WBA:   w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  // State, IR and the sticky illegal flag all freeze while rdy is low.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= S_FETCH;
      r_ir      <= 8'hEA;
      r_illegal <= 1'b0;
    end else if (bus.rdy) begin
      r_state <= w_next;
      if (r_state == S_FETCH) r_ir <= bus.din;
      if (w_ill_set)          r_illegal <= 1'b1;
    end
  end

  // Moore strobe decode of the registered state.
  always_comb begin
    w_ctrl_raw = '0;
    w_rw       = 1'b1;
    w_sync     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl_raw = PCRD;
        w_sync     = 1'b1;
      end
      S_DEC: if (w_dec_fetch) w_ctrl_raw = PCRD;
      S_ADL: begin
        // Low address byte goes into both pre-ALU inputs so MEM can OR it
        // through unchanged onto ADL.
        w_ctrl_raw[B_DLADLOA]  = 1'b1;
        w_ctrl_raw[B_PREADLWA] = 1'b1;
        w_ctrl_raw[B_DLDBOA]   = 1'b1;
        w_ctrl_raw[B_PREDBWA]  = 1'b1;
      end
      S_ADH: w_ctrl_raw = PCRD;
      S_MEM: begin
        w_ctrl_raw[B_ORS]      = 1'b1;
        w_ctrl_raw[B_ALUADLOA] = 1'b1;
        w_ctrl_raw[B_ABLWA]    = 1'b1;
        w_ctrl_raw[B_DLADHOA]  = 1'b1;
        w_ctrl_raw[B_ABHWA]    = 1'b1;
      end
      S_RDM: w_ctrl_raw[B_DLWA] = 1'b1;
      S_STM: begin
        w_ctrl_raw[B_ACCDBOA] = 1'b1;
        w_ctrl_raw[B_DORWA]   = 1'b1;
        w_ctrl_raw[B_DOROA]   = 1'b1;
        w_rw                  = 1'b0;
      end
      S_LDALU: begin
        w_ctrl_raw[B_DLDBOA]  = 1'b1;
        w_ctrl_raw[B_PREDBWA] = 1'b1;
        w_ctrl_raw[B_ACCSBOA] = 1'b1;
        w_ctrl_raw[B_PRESBWA] = 1'b1;
      end
      S_ALU: begin
        w_ctrl_raw[B_SUMS]   = 1'b1;
        w_ctrl_raw[B_CIN]    = bus.carry_in;
        w_ctrl_raw[B_SALUWA] = 1'b1;
      end
      S_WBL: begin
        w_ctrl_raw[B_DLDBOA] = 1'b1;
        w_ctrl_raw[B_DBSB]   = 1'b1;
        w_ctrl_raw[B_ACCWA]  = 1'b1;
      end
      S_WBA: begin
        w_ctrl_raw[B_ALUSBOA] = 1'b1;
        w_ctrl_raw[B_ACCWA]   = 1'b1;
      end
      default: w_ctrl_raw = '0;
    endcase
  end

  // clr_n gates the outputs directly so the board sees quiet strobes for the
  // whole time reset is held, not just after the next edge.
  assign bus.ctrl    = !clr_n  ? 24'd0 :
                       bus.rdy ? w_ctrl_raw : (w_ctrl_raw & ~WR_MASK);
  assign bus.rw      = clr_n ? w_rw : 1'b1;
  assign bus.sync    = clr_n & w_sync;
  assign bus.t_state = r_state;
  assign bus.ir      = r_ir;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer
//   Directed-vector bench for opcode_sequencer. Inputs are driven on the
//   falling edge and outputs are checked 1 ns later, away from the rising edge.
module tb_opcode_sequencer;

  localparam logic [3:0] FETCH = 4'd0, DEC = 4'd1, ADL = 4'd2, ADH = 4'd3,
                         MEM = 4'd4, RDM = 4'd5, STM = 4'd6, LDALU = 4'd7,
                         ALU = 4'd8, WBL = 4'd9, WBA = 4'd10;

  // Hand-computed strobe words per state.
  localparam logic [23:0] C_PCRD   = 24'h0001F1; // bits 0,4,5,6,7,8
  localparam logic [23:0] C_NONE   = 24'h000000;
  localparam logic [23:0] C_ADL    = 24'h006006; // bits 1,2,13,14
  localparam logic [23:0] C_MEM    = 24'h110188; // bits 3,7,8,16,20
  localparam logic [23:0] C_RDM    = 24'h000001; // bit 0
  localparam logic [23:0] C_STM    = 24'hC01000; // bits 12,22,23
  localparam logic [23:0] C_LDALU  = 24'h00A802; // bits 1,11,13,15
  localparam logic [23:0] C_ALU0   = 24'h0A0000; // bits 17,19
  localparam logic [23:0] C_ALU1   = 24'h0E0000; // bits 17,18,19
  localparam logic [23:0] C_WBL    = 24'h000602; // bits 1,9,10
  localparam logic [23:0] C_WBA    = 24'h200400; // bits 10,21
  localparam logic [23:0] C_FSTALL = 24'h000060; // PCRD minus write bits

  logic clk;
  logic clr_n;
  int   n_chk;
  int   n_err;

  opcode_sequencer_if bus ();

  opcode_sequencer dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, then check state, strobes, sync and rw.
  task automatic cyc(input string tag, input logic [7:0] d, input logic r,
                     input logic c, input logic [3:0] es,
                     input logic [23:0] ec);
    @(negedge clk);
    bus.din      = d;
    bus.rdy      = r;
    bus.carry_in = c;
    #1;
    chk({tag, "/state"}, 32'(bus.t_state), 32'(es));
    chk({tag, "/ctrl"},  32'(bus.ctrl),    32'(ec));
    chk({tag, "/sync"},  32'(bus.sync),    32'(es == FETCH));
    chk({tag, "/rw"},    32'(bus.rw),      32'(es != STM));
  endtask

  // Release reset on a falling edge and check the first FETCH cycle.
  task automatic release_chk(input string tag, input logic [7:0] d);
    @(negedge clk);
    clr_n   = 1'b1;
    bus.din = d;
    bus.rdy = 1'b1;
    #1;
    chk({tag, "/state"}, 32'(bus.t_state), 32'(FETCH));
    chk({tag, "/ctrl"},  32'(bus.ctrl),    32'(C_PCRD));
    chk({tag, "/sync"},  32'(bus.sync),    32'd1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "/ctrl"},    32'(bus.ctrl),    32'd0);
    chk({tag, "/rw"},      32'(bus.rw),      32'd1);
    chk({tag, "/sync"},    32'(bus.sync),    32'd0);
    chk({tag, "/ir"},      32'(bus.ir),      32'hEA);
    chk({tag, "/illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, "/state"},   32'(bus.t_state), 32'(FETCH));
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    clr_n        = 1'b0;
    bus.din      = 8'h00;
    bus.rdy      = 1'b1;
    bus.carry_in = 1'b0;

    // Reset held across several edges.
    repeat (3) @(negedge clk);
    #1;
    reset_chk("por");

    // NOP: 2 cycles.
    release_chk("nop_f", 8'hEA);
    cyc("nop_d", 8'h00, 1, 0, DEC, C_NONE);
    chk("nop_ir", 32'(bus.ir), 32'hEA);

    // LDA #05: 0,1,9.
    cyc("ldai_f", 8'hA9, 1, 0, FETCH, C_PCRD);
    cyc("ldai_d", 8'h05, 1, 0, DEC,   C_PCRD);
    chk("ldai_ir", 32'(bus.ir), 32'hA9);
    cyc("ldai_w", 8'h05, 1, 0, WBL,   C_WBL);

    // ADC abs 0006 with carry_in=1: 0,1,2,3,4,5,7,8,10.
    cyc("adca_f",  8'h6D, 1, 1, FETCH, C_PCRD);
    cyc("adca_d",  8'h06, 1, 1, DEC,   C_PCRD);
    cyc("adca_al", 8'h06, 1, 1, ADL,   C_ADL);
    cyc("adca_ah", 8'h00, 1, 1, ADH,   C_PCRD);
    cyc("adca_m",  8'h00, 1, 1, MEM,   C_MEM);
    cyc("adca_r",  8'h0F, 1, 1, RDM,   C_RDM);
    cyc("adca_l",  8'h0F, 1, 1, LDALU, C_LDALU);
    cyc("adca_u",  8'h0F, 1, 1, ALU,   C_ALU1);
    cyc("adca_w",  8'h0F, 1, 1, WBA,   C_WBA);

    // ADC #imm with carry_in=0: 0,1,7,8,10.
    cyc("adci_f", 8'h69, 1, 0, FETCH, C_PCRD);
    cyc("adci_d", 8'h22, 1, 0, DEC,   C_PCRD);
    cyc("adci_l", 8'h22, 1, 0, LDALU, C_LDALU);
    cyc("adci_u", 8'h22, 1, 0, ALU,   C_ALU0);
    cyc("adci_w", 8'h22, 1, 0, WBA,   C_WBA);

    // STA abs 1234: 0,1,2,3,4,6.
    cyc("sta_f",  8'h8D, 1, 0, FETCH, C_PCRD);
    cyc("sta_d",  8'h34, 1, 0, DEC,   C_PCRD);
    cyc("sta_al", 8'h34, 1, 0, ADL,   C_ADL);
    cyc("sta_ah", 8'h12, 1, 0, ADH,   C_PCRD);
    cyc("sta_m",  8'h12, 1, 0, MEM,   C_MEM);
    cyc("sta_s",  8'h00, 1, 0, STM,   C_STM);

    // LDA abs with a 3-cycle stall in RDM: 10 cycles total.
    cyc("ldaa_f",  8'hAD, 1, 0, FETCH, C_PCRD);
    cyc("ldaa_d",  8'h00, 1, 0, DEC,   C_PCRD);
    cyc("ldaa_al", 8'h00, 1, 0, ADL,   C_ADL);
    cyc("ldaa_ah", 8'h02, 1, 0, ADH,   C_PCRD);
    cyc("ldaa_m",  8'h02, 1, 0, MEM,   C_MEM);
    cyc("ldaa_s1", 8'h77, 0, 0, RDM,   C_NONE);
    cyc("ldaa_s2", 8'h77, 0, 0, RDM,   C_NONE);
    cyc("ldaa_s3", 8'h77, 0, 0, RDM,   C_NONE);
    cyc("ldaa_r",  8'h77, 1, 0, RDM,   C_RDM);
    cyc("ldaa_w",  8'h77, 1, 0, WBL,   C_WBL);

    // Stall in FETCH: the opcode on din while stalled must not load.
    cyc("fst_s", 8'h8D, 0, 0, FETCH, C_FSTALL);
    cyc("fst_f", 8'hEA, 1, 0, FETCH, C_PCRD);
    cyc("fst_d", 8'h00, 1, 0, DEC,   C_NONE);
    chk("fst_ir", 32'(bus.ir), 32'hEA);

    // Illegal opcode FF, then a NOP; flag is sticky.
    cyc("ill_f", 8'hFF, 1, 0, FETCH, C_PCRD);
    cyc("ill_d", 8'h00, 1, 0, DEC,   C_NONE);
    chk("ill_pre", 32'(bus.illegal), 32'd0);
    cyc("ill_nf", 8'hEA, 1, 0, FETCH, C_PCRD);
    chk("ill_set", 32'(bus.illegal), 32'd1);
    cyc("ill_nd", 8'h00, 1, 0, DEC,   C_NONE);
    cyc("ill_n2", 8'hEA, 1, 0, FETCH, C_PCRD);
    chk("ill_hold", 32'(bus.illegal), 32'd1);

    // Reset asserted in the middle of ADH of an LDA abs.
    cyc("rst_d",  8'hAD, 1, 0, DEC,   C_NONE);
    cyc("rst_f",  8'hAD, 1, 0, FETCH, C_PCRD);
    cyc("rst_dd", 8'h10, 1, 0, DEC,   C_PCRD);
    cyc("rst_al", 8'h10, 1, 0, ADL,   C_ADL);
    cyc("rst_ah", 8'h20, 1, 0, ADH,   C_PCRD);
    #1;
    clr_n = 1'b0;
    #1;
    reset_chk("mid");
    release_chk("rel", 8'hEA);
    cyc("rel_d", 8'h00, 1, 0, DEC, C_NONE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
